io_pmp_err_slv: RTL and testbench

Terminating AXI error slave placed directly downstream of the IO-PMP permission check. It absorbs every transaction the PMP rejects and answers with a spec-compliant error response. A burst write is drained and answered with one B beat. A burst read is answered with len+1 R beats, each carrying the configured error code, so the denied master never hangs.

---
 rtl/axi_conf.sv | 11 +
 rtl/io_pmp_err_slv.sv | 94 +++++++++
 tb/tb_io_pmp_err_slv.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_conf.sv
// axi_conf: AXI response codes and the error-slave FSM state encodings
package axi_conf;
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_trans_resp_t;
  typedef enum logic [1:0] {W_IDLE, W_DRAIN, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_BURST} r_state_t;
endpackage

// File: rtl/io_pmp_err_slv.sv
// io_pmp_err_slv: terminating AXI error slave behind the IO-PMP; IO_PMP_ERR_CNT_EN adds err_cnt_o
module io_pmp_err_slv
  import axi_conf::*;
#(
  parameter int ID_WIDTH = 4,
  parameter int DATA_WIDTH = 64,
  parameter axi_trans_resp_t RESP = RESP_SLVERR
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  aw_valid_i,
  output logic                  aw_ready_o,
  input  logic [ID_WIDTH-1:0]   aw_id_i,
  input  logic                  w_valid_i,
  output logic                  w_ready_o,
  input  logic                  w_last_i,
  output logic                  b_valid_o,
  input  logic                  b_ready_i,
  output logic [ID_WIDTH-1:0]   b_id_o,
  output logic [1:0]            b_resp_o,
  input  logic                  ar_valid_i,
  output logic                  ar_ready_o,
  input  logic [ID_WIDTH-1:0]   ar_id_i,
  input  logic [7:0]            ar_len_i,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  output logic [ID_WIDTH-1:0]   r_id_o,
  output logic [DATA_WIDTH-1:0] r_data_o,
  output logic [1:0]            r_resp_o,
  output logic                  r_last_o
`ifdef IO_PMP_ERR_CNT_EN
  ,
  output logic [15:0]           err_cnt_o
`endif
);
  w_state_t w_state;
  r_state_t r_state;
  logic [7:0] r_len, r_cnt;
  logic aw_hs, ar_hs;
  assign aw_ready_o = w_state == W_IDLE;
  assign w_ready_o  = w_state == W_DRAIN;
  assign b_valid_o  = w_state == W_RESP;
  assign ar_ready_o = r_state == R_IDLE;
  assign r_valid_o  = r_state == R_BURST;
  assign r_last_o   = r_valid_o && r_cnt == r_len;
  assign b_resp_o   = RESP;
  assign r_resp_o   = RESP;
  assign r_data_o   = '0;
  assign aw_hs      = aw_valid_i && aw_ready_o;
  assign ar_hs      = ar_valid_i && ar_ready_o;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state <= W_IDLE;
      b_id_o  <= '0;
    end else begin
      case (w_state)
        W_IDLE:  if (aw_hs) begin
          b_id_o  <= aw_id_i;
          w_state <= W_DRAIN;
        end
        W_DRAIN: if (w_valid_i && w_last_i) w_state <= W_RESP;
        W_RESP:  if (b_ready_i) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end
  // the beat counter stops at the latched length, so a 256-beat burst never wraps it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= R_IDLE;
      r_id_o  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
    end else if (r_state == R_IDLE) begin
      if (ar_hs) begin
        r_id_o  <= ar_id_i;
        r_len   <= ar_len_i;
        r_cnt   <= '0;
        r_state <= R_BURST;
      end
    end else if (r_ready_i) begin
      r_cnt   <= r_last_o ? r_cnt : r_cnt + 8'd1;
      r_state <= r_last_o ? R_IDLE : R_BURST;
    end
  end
`ifdef IO_PMP_ERR_CNT_EN
  logic [16:0] cnt_sum;
  assign cnt_sum = {1'b0, err_cnt_o} + 17'(aw_hs) + 17'(ar_hs);
  always_ff @(posedge clk_i) begin
    if (rst_i) err_cnt_o <= '0;
    else err_cnt_o <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end
`endif
endmodule

// File: tb/tb_io_pmp_err_slv.sv
// tb_io_pmp_err_slv: directed and randomized checks of io_pmp_err_slv against a burst-level model
module tb_io_pmp_err_slv;
  logic clk = 0, rst = 1;
  logic aw_valid = 0, aw_ready, w_valid = 0, w_ready, w_last = 0;
  logic b_valid, b_ready = 0, ar_valid = 0, ar_ready, r_valid, r_ready = 0, r_last;
  logic [3:0] aw_id = 0, b_id, ar_id = 0, r_id;
  logic [7:0] ar_len = 0;
  logic [1:0] b_resp, r_resp;
  logic [63:0] r_data;
  int checks = 0, errors = 0;
`ifdef IO_PMP_ERR_CNT_EN
  logic [15:0] err_cnt;
  int exp_cnt = 0;
`endif

  io_pmp_err_slv dut (
    .clk_i(clk), .rst_i(rst),
    .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_id_i(aw_id),
    .w_valid_i(w_valid), .w_ready_o(w_ready), .w_last_i(w_last),
    .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
    .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id), .ar_len_i(ar_len),
    .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id), .r_data_o(r_data),
    .r_resp_o(r_resp), .r_last_o(r_last)
`ifdef IO_PMP_ERR_CNT_EN
    , .err_cnt_o(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive one AW plus n W beats (random gaps), then accept B after d stall cycles
  task automatic do_write(input logic [3:0] id, input int n, input int d);
    int k = 0, cyc = 0;
    aw_valid = 1; aw_id = id;
    chk("aw_ready", aw_ready, 1);
    tick;
    aw_valid = 0;
    while (k < n && cyc < 100) begin
      w_valid = 1'($urandom_range(0, 1));
      w_last = (k == n - 1);
      chk("w_ready", w_ready, 1);
      chk("b_early", b_valid, 0);
      chk("aw_busy", aw_ready, 0);
      if (w_valid) k++;
      tick;
      cyc++;
    end
    w_valid = 0; w_last = 0;
    repeat (d) begin
      chk("b_hold", b_valid, 1);
      chk("b_id", b_id, id);
      chk("w_closed", w_ready, 0);
      tick;
    end
    b_ready = 1;
    chk("b_valid", b_valid, 1);
    chk("b_resp", b_resp, 2'b10);
    tick;
    b_ready = 0;
    chk("b_once", b_valid, 0);
    chk("aw_back", aw_ready, 1);
  endtask

  // issue one AR and accept len+1 beats with random back-pressure
  task automatic do_read(input logic [3:0] id, input int len, input bit rnd);
    int k = 0, cyc = 0;
    ar_valid = 1; ar_id = id; ar_len = 8'(len);
    chk("ar_ready", ar_ready, 1);
    tick;
    ar_valid = 0;
    while (k <= len && cyc < 2000) begin
      r_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("r_valid", r_valid, 1);
      chk("r_last", r_last, k == len);
      chk("r_id", r_id, id);
      chk("r_data", r_data, 0);
      chk("r_resp", r_resp, 2'b10);
      if (r_ready) k++;
      tick;
      cyc++;
    end
    r_ready = 0;
    chk("r_beats", k, len + 1);
    chk("r_done", r_valid, 0);
    chk("ar_back", ar_ready, 1);
  endtask

  initial begin
    tick; tick;
    rst = 0;
    chk("rst_aw_ready", aw_ready, 1);
    chk("rst_ar_ready", ar_ready, 1);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_r_last", r_last, 0);
    chk("rst_b_id", b_id, 0);
    chk("rst_r_id", r_id, 0);
`ifdef IO_PMP_ERR_CNT_EN
    chk("rst_cnt", err_cnt, 0);
`endif
    // W beats offered before any AW must not be taken
    w_valid = 1; w_last = 1;
    chk("w_before_aw", w_ready, 0);
    tick;
    chk("no_b_without_aw", b_valid, 0);
    w_valid = 0; w_last = 0;
    // four-beat write, B one cycle after the last W
    aw_valid = 1; aw_id = 3;
    tick;
    aw_valid = 0;
    for (int i = 0; i < 4; i++) begin
      w_valid = 1; w_last = (i == 3);
      chk("w4_ready", w_ready, 1);
      chk("w4_no_b", b_valid, 0);
      tick;
    end
    w_valid = 0; w_last = 0;
    chk("w4_b_valid", b_valid, 1);
    chk("w4_b_id", b_id, 3);
    chk("w4_b_resp", b_resp, 2'b10);
    b_ready = 1;
    tick;
    b_ready = 0;
    chk("w4_b_gone", b_valid, 0);
    // four-beat read at full rate, then single beat under stalls
    do_read(5, 3, 0);
    ar_valid = 1; ar_id = 9; ar_len = 0;
    tick;
    ar_valid = 0;
    repeat (3) begin
      chk("stall_valid", r_valid, 1);
      chk("stall_last", r_last, 1);
      chk("stall_id", r_id, 9);
      tick;
    end
    r_ready = 1;
    tick;
    r_ready = 0;
    chk("stall_done", r_valid, 0);
    // simultaneous AW and AR; read finishes while B is back-pressured
    aw_valid = 1; aw_id = 6; ar_valid = 1; ar_id = 7; ar_len = 1;
    chk("sim_aw_ready", aw_ready, 1);
    chk("sim_ar_ready", ar_ready, 1);
    tick;
    aw_valid = 0; ar_valid = 0;
    w_valid = 1; w_last = 1; r_ready = 1;
    chk("sim_r0", r_valid, 1);
    chk("sim_r0_last", r_last, 0);
    tick;
    w_valid = 0; w_last = 0;
    chk("sim_r1_last", r_last, 1);
    chk("sim_r1_id", r_id, 7);
    tick;
    r_ready = 0;
    chk("sim_r_done", r_valid, 0);
    repeat (10) begin
      chk("sim_b_hold", b_valid, 1);
      chk("sim_b_id", b_id, 6);
      tick;
    end
    b_ready = 1;
    tick;
    b_ready = 0;
    chk("sim_b_gone", b_valid, 0);
`ifdef IO_PMP_ERR_CNT_EN
    chk("cnt_5", err_cnt, 5);
`endif
    // reset during beat 2 of an 8-beat read drops the burst
    ar_valid = 1; ar_id = 2; ar_len = 7; r_ready = 1;
    tick;
    ar_valid = 0;
    tick;
    chk("mid_r_valid", r_valid, 1);
    rst = 1;
    tick;
    rst = 0; r_ready = 0;
    chk("mid_rst_r_valid", r_valid, 0);
    chk("mid_rst_ar_ready", ar_ready, 1);
    chk("mid_rst_r_last", r_last, 0);
    do_read(4, 2, 0);
    do_read(1, 255, 0);
    // randomized transactions against the burst model
    for (int i = 0; i < 30; i++) begin
      do_write(4'($urandom), $urandom_range(1, 8), $urandom_range(0, 4));
      do_read(4'($urandom), $urandom_range(0, 15), 1);
    end
`ifdef IO_PMP_ERR_CNT_EN
    exp_cnt = 2 + 60;
    chk("cnt_rand", err_cnt, 16'(exp_cnt));
    aw_valid = 1; ar_valid = 1; w_valid = 1; w_last = 1;
    b_ready = 1; r_ready = 1; ar_len = 0;
    for (int c = 0; c < 90000 && err_cnt != 16'hFFFF; c++) tick;
    repeat (20) tick;
    chk("cnt_sat", err_cnt, 16'hFFFF);
    aw_valid = 0; ar_valid = 0; w_valid = 0; w_last = 0;
    rst = 1;
    tick;
    rst = 0;
    chk("cnt_clr", err_cnt, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
